// File: rtl/sbox_sched.sv
// sbox_sched: schedules state (16 B) and key-word (4 B) SubBytes jobs
// onto one shared external S-box pipeline, one job in flight at a time.
module sbox_sched #(
  parameter int SBOX_LAT = 2
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         st_valid_in,
  output logic         st_ready_out,
  input  logic [127:0] st_in,
  output logic         st_valid_out,
  output logic [127:0] st_out,
  input  logic         kw_valid_in,
  output logic         kw_ready_out,
  input  logic [31:0]  kw_in,
  output logic         kw_valid_out,
  output logic [31:0]  kw_out,
  output logic [7:0]   sbox_x_out,
  output logic         sbox_x_valid_out,
  input  logic [7:0]   sbox_y_in,
  output logic         busy_out
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t              state;
  logic [127:0]        job;
  logic [127:0]        res;
  logic [127:0]        fin;
  logic                is_key;
  logic                last_key;
  logic [3:0]          iidx;
  logic [3:0]          ridx;
  logic [3:0]          last;
  logic [SBOX_LAT-1:0] vsr;
  logic                idle;
  logic                st_go;
  logic                kw_go;
  logic                ret;

  // Round-robin grant; the loser of a tie sees ready low.
  assign idle         = (state == IDLE) && !rst_in;
  assign st_ready_out = idle && (!kw_valid_in || last_key);
  assign kw_ready_out = idle && (!st_valid_in || !last_key);
  assign st_go        = st_valid_in && st_ready_out;
  assign kw_go        = kw_valid_in && kw_ready_out;

  assign last     = is_key ? 4'd3 : 4'd15;
  assign ret      = vsr[SBOX_LAT-1];
  assign busy_out = (state != IDLE);

  assign sbox_x_valid_out = (state == ISSUE);
  assign sbox_x_out = sbox_x_valid_out ?
                      job[{iidx, 3'b000} +: 8] : 8'h00;

  // Result vector with the byte returning this cycle merged in.
  always_comb begin
    fin = res;
    fin[{ridx, 3'b000} +: 8] = sbox_y_in;
  end

  // Return tracker: marks which cycles carry a live S-box result.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      vsr <= '0;
    end else begin
      vsr[0] <= sbox_x_valid_out;
      for (int i = 1; i < SBOX_LAT; i++) begin
        vsr[i] <= vsr[i-1];
      end
    end
  end

  // Job FSM: accept, issue bytes, collect returns, pulse result.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= IDLE;
      job          <= '0;
      res          <= '0;
      is_key       <= 1'b0;
      last_key     <= 1'b0;
      iidx         <= '0;
      ridx         <= '0;
      st_valid_out <= 1'b0;
      kw_valid_out <= 1'b0;
      st_out       <= '0;
      kw_out       <= '0;
    end else begin
      st_valid_out <= 1'b0;
      kw_valid_out <= 1'b0;
      if (ret) begin
        res[{ridx, 3'b000} +: 8] <= sbox_y_in;
        ridx <= ridx + 4'd1;
      end
      unique case (state)
        IDLE: begin
          if (st_go || kw_go) begin
            is_key   <= kw_go;
            last_key <= kw_go;
            job      <= kw_go ? {96'b0, kw_in} : st_in;
            iidx     <= '0;
            ridx     <= '0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (iidx == last) begin
            state <= WAIT;
          end else begin
            iidx <= iidx + 4'd1;
          end
        end
        WAIT: begin
          if (ret && (ridx == last)) begin
            state <= DONE;
            if (is_key) begin
              kw_valid_out <= 1'b1;
              kw_out       <= fin[31:0];
            end else begin
              st_valid_out <= 1'b1;
              st_out       <= fin;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sbox_sched.sv
// tb_sbox_sched: random + directed checks of sbox_sched against a
// job-level schedule model and an AES S-box built from GF(2^8).
module tb_sbox_sched;

  localparam int LAT = 2;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc++;

  int total = 0;
  int bad = 0;
  bit side_done = 1'b0;

  logic [7:0] sbox_tab [256];

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    logic hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rol(logic [7:0] v, int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_tab[x] = inv ^ rol(inv, 1) ^ rol(inv, 2) ^
                    rol(inv, 3) ^ rol(inv, 4) ^ 8'h63;
    end
  end

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // main DUT
  logic         rst_in;
  logic         st_valid_in, st_ready_out, st_valid_out;
  logic [127:0] st_in, st_out;
  logic         kw_valid_in, kw_ready_out, kw_valid_out;
  logic [31:0]  kw_in, kw_out;
  logic [7:0]   sbox_x_out, sbox_y_in;
  logic         sbox_x_valid_out, busy_out;
  logic [7:0]   pa [8];

  sbox_sched #(.SBOX_LAT(LAT)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .st_valid_in(st_valid_in), .st_ready_out(st_ready_out),
    .st_in(st_in), .st_valid_out(st_valid_out), .st_out(st_out),
    .kw_valid_in(kw_valid_in), .kw_ready_out(kw_ready_out),
    .kw_in(kw_in), .kw_valid_out(kw_valid_out), .kw_out(kw_out),
    .sbox_x_out(sbox_x_out), .sbox_x_valid_out(sbox_x_valid_out),
    .sbox_y_in(sbox_y_in), .busy_out(busy_out)
  );

  always @(posedge clk_in) begin
    pa[0] <= sbox_tab[sbox_x_out];
    for (int i = 1; i < 8; i++) pa[i] <= pa[i-1];
  end
  assign sbox_y_in = pa[LAT-1];

  // side DUTs at SBOX_LAT = 1 and 8, sharing one stimulus
  logic         rst_s, sv_s, kv_s;
  logic [127:0] si_s;
  logic [31:0]  ki_s;
  logic         sr_b, svo_b, kr_b, kvo_b, xv_b, bz_b;
  logic [127:0] so_b;
  logic [31:0]  ko_b;
  logic [7:0]   x_b, y_b;
  logic         sr_c, svo_c, kr_c, kvo_c, xv_c, bz_c;
  logic [127:0] so_c;
  logic [31:0]  ko_c;
  logic [7:0]   x_c, y_c;
  logic [7:0]   pb [8];
  logic [7:0]   pc [8];

  sbox_sched #(.SBOX_LAT(1)) dut_b (
    .clk_in(clk_in), .rst_in(rst_s),
    .st_valid_in(sv_s), .st_ready_out(sr_b),
    .st_in(si_s), .st_valid_out(svo_b), .st_out(so_b),
    .kw_valid_in(kv_s), .kw_ready_out(kr_b),
    .kw_in(ki_s), .kw_valid_out(kvo_b), .kw_out(ko_b),
    .sbox_x_out(x_b), .sbox_x_valid_out(xv_b),
    .sbox_y_in(y_b), .busy_out(bz_b)
  );

  sbox_sched #(.SBOX_LAT(8)) dut_c (
    .clk_in(clk_in), .rst_in(rst_s),
    .st_valid_in(sv_s), .st_ready_out(sr_c),
    .st_in(si_s), .st_valid_out(svo_c), .st_out(so_c),
    .kw_valid_in(kv_s), .kw_ready_out(kr_c),
    .kw_in(ki_s), .kw_valid_out(kvo_c), .kw_out(ko_c),
    .sbox_x_out(x_c), .sbox_x_valid_out(xv_c),
    .sbox_y_in(y_c), .busy_out(bz_c)
  );

  always @(posedge clk_in) begin
    pb[0] <= sbox_tab[x_b];
    pc[0] <= sbox_tab[x_c];
    for (int i = 1; i < 8; i++) begin
      pb[i] <= pb[i-1];
      pc[i] <= pc[i-1];
    end
  end
  assign y_b = pb[0];
  assign y_c = pc[7];

  // job-level model of the main DUT, checked every cycle
  bit           m_act = 1'b0, m_key = 1'b0, m_lk = 1'b0;
  int           m_c0 = 0, m_n = 0, m_done = 0;
  logic [127:0] m_data = '0, m_res = '0, m_st = '0;
  logic [31:0]  m_kw = '0;

  always @(negedge clk_in) begin
    bit idle, er_s, er_k, ex_v;
    logic [7:0] ex_x;
    if (rst_in) begin
      chk("st_ready_rst", st_ready_out, 0);
      chk("kw_ready_rst", kw_ready_out, 0);
      m_act = 1'b0; m_lk = 1'b0; m_st = '0; m_kw = '0;
    end else begin
      idle = !m_act;
      er_s = idle && (!kw_valid_in || m_lk);
      er_k = idle && (!st_valid_in || !m_lk);
      chk("st_ready", st_ready_out, er_s);
      chk("kw_ready", kw_ready_out, er_k);
      if (m_act && cyc == m_done) begin
        if (m_key) m_kw = m_res[31:0];
        else m_st = m_res;
      end
      ex_v = m_act && cyc > m_c0 && cyc <= m_c0 + m_n;
      ex_x = ex_v ? m_data[8*(cyc-m_c0-1) +: 8] : 8'h00;
      chk("x_valid", sbox_x_valid_out, ex_v);
      chk("x_byte", sbox_x_out, ex_x);
      chk("st_pulse", st_valid_out, m_act && cyc == m_done && !m_key);
      chk("kw_pulse", kw_valid_out, m_act && cyc == m_done && m_key);
      chk("st_out", st_out, m_st);
      chk("kw_out", kw_out, m_kw);
      chk("busy", busy_out, m_act && cyc > m_c0);
      if (m_act && cyc == m_done) m_act = 1'b0;
      if ((st_valid_in && er_s) || (kw_valid_in && er_k)) begin
        m_act  = 1'b1;
        m_key  = kw_valid_in && er_k;
        m_lk   = m_key;
        m_c0   = cyc;
        m_n    = m_key ? 4 : 16;
        m_data = m_key ? {96'b0, kw_in} : st_in;
        m_res  = '0;
        for (int k = 0; k < m_n; k++)
          m_res[8*k +: 8] = sbox_tab[m_data[8*k +: 8]];
        m_done = cyc + m_n + LAT + 1;
      end
    end
  end

  task automatic do_job(input bit isk, input logic [127:0] d,
                        output int c0);
    c0 = -1;
    @(posedge clk_in); #1;
    if (isk) begin kw_in = d[31:0]; kw_valid_in = 1'b1; end
    else begin st_in = d; st_valid_in = 1'b1; end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_in);
      if (isk ? kw_ready_out : st_ready_out) begin
        c0 = cyc;
        break;
      end
    end
    @(posedge clk_in); #1;
    st_valid_in = 1'b0;
    kw_valid_in = 1'b0;
    st_in = {$urandom, $urandom, $urandom, $urandom};
    kw_in = $urandom;
    chk("handshake_seen", c0 >= 0, 1);
  endtask

  task automatic wait_pulse(input bit isk, output int pc,
                            output logic [127:0] v);
    pc = -1;
    v = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_in);
      if (isk ? kw_valid_out : st_valid_out) begin
        pc = cyc;
        v = isk ? {96'b0, kw_out} : st_out;
        break;
      end
    end
    chk("pulse_seen", pc >= 0, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_in);
      if (!busy_out) break;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, want finish");
    $fatal(1, "watchdog");
  end

  // side DUTs: all-zero state at SBOX_LAT 1 and 8
  initial begin
    int c0, pb_c, pc_c, nb, nc;
    logic [127:0] vb, vc;
    rst_s = 1'b1; sv_s = 1'b0; kv_s = 1'b0; si_s = '0; ki_s = '0;
    c0 = -1; pb_c = -1; pc_c = -1; nb = 0; nc = 0; vb = '0; vc = '0;
    repeat (3) @(posedge clk_in);
    #1 rst_s = 1'b0;
    @(posedge clk_in); #1 sv_s = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (sr_b && sr_c) begin c0 = cyc; break; end
    end
    @(posedge clk_in); #1 sv_s = 1'b0; si_s = '1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      if (svo_b) begin nb++; pb_c = cyc; vb = so_b; end
      if (svo_c) begin nc++; pc_c = cyc; vc = so_c; end
    end
    chk("lat1_hs", c0 >= 0, 1);
    chk("lat1_cycles", pb_c - c0, 18);
    chk("lat8_cycles", pc_c - c0, 25);
    chk("lat1_pulses", nb, 1);
    chk("lat8_pulses", nc, 1);
    chk("lat1_value", vb, {16{8'h63}});
    chk("lat8_value", vc, {16{8'h63}});
    side_done = 1'b1;
  end

  initial begin
    int c0, pc, n, last_hs;
    int seq [3];
    logic [127:0] v;
    rst_in = 1'b1;
    st_valid_in = 1'b0; kw_valid_in = 1'b0;
    st_in = '0; kw_in = '0;
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;

    chk("sbox_00", sbox_tab[8'h00], 8'h63);
    chk("sbox_01", sbox_tab[8'h01], 8'h7c);
    chk("sbox_53", sbox_tab[8'h53], 8'hed);

    // ties after reset: key, state, key
    @(posedge clk_in); #1;
    st_valid_in = 1'b1; kw_valid_in = 1'b1;
    n = 0;
    for (int i = 0; i < 100 && n < 3; i++) begin
      @(negedge clk_in);
      if (st_valid_in && st_ready_out) begin seq[n] = 0; n++; end
      else if (kw_valid_in && kw_ready_out) begin seq[n] = 1; n++; end
    end
    @(posedge clk_in); #1;
    st_valid_in = 1'b0; kw_valid_in = 1'b0;
    chk("tie_count", n, 3);
    chk("tie1_key", seq[0], 1);
    chk("tie2_state", seq[1], 0);
    chk("tie3_key", seq[2], 1);
    wait_idle();

    do_job(1'b0, '0, c0);
    wait_pulse(1'b0, pc, v);
    chk("zero_lat", pc - c0, 19);
    chk("zero_val", v, {16{8'h63}});

    do_job(1'b1, 128'h53, c0);
    wait_pulse(1'b1, pc, v);
    chk("key_lat", pc - c0, 7);
    chk("key_val", v, 128'h636363ed);

    // reset while byte 8 of a state job is on the bus
    do_job(1'b0, {$urandom, $urandom, $urandom, $urandom}, c0);
    while (cyc < c0 + 9) begin @(posedge clk_in); #1; end
    chk("byte8_live", sbox_x_valid_out, 1);
    rst_in = 1'b1;
    @(posedge clk_in); #1 rst_in = 1'b0;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_in);
      if (st_valid_out) n++;
    end
    chk("no_pulse_after_rst", n, 0);
    do_job(1'b0, {16{8'h53}}, c0);
    wait_pulse(1'b0, pc, v);
    chk("post_rst_lat", pc - c0, 19);
    chk("post_rst_val", v, {16{8'hed}});

    // back-to-back state jobs
    @(posedge clk_in); #1;
    st_valid_in = 1'b1;
    st_in = {$urandom, $urandom, $urandom, $urandom};
    n = 0; last_hs = -1;
    for (int i = 0; i < 200 && n < 6; i++) begin
      @(negedge clk_in);
      if (st_ready_out) begin
        if (last_hs >= 0) chk("b2b_spacing", cyc - last_hs, 20);
        last_hs = cyc;
        n++;
        @(posedge clk_in); #1;
        st_in = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    chk("b2b_jobs", n, 6);
    @(posedge clk_in); #1 st_valid_in = 1'b0;
    wait_idle();

    // random traffic, data churn and rare resets
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk_in); #1;
      st_valid_in = $urandom_range(0, 2) == 0;
      kw_valid_in = $urandom_range(0, 2) == 0;
      st_in = {$urandom, $urandom, $urandom, $urandom};
      kw_in = $urandom;
      rst_in = $urandom_range(0, 249) == 0;
    end
    @(posedge clk_in); #1;
    rst_in = 1'b0; st_valid_in = 1'b0; kw_valid_in = 1'b0;
    repeat (30) @(posedge clk_in);

    for (int i = 0; i < 100 && !side_done; i++) @(posedge clk_in);
    chk("side_done", side_done, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sbox_sched.md
SBOX_SCHED -- requirements
Module: sbox_sched

Interface
REQ-001 SHALL have parameter SBOX_LAT, default 2: cycles from a byte on sbox_x_out to its result on sbox_y_in; legal range 1..8.
REQ-002 SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port: clk_in  input  1  clock; all logic on the rising edge.
REQ-004 Port: rst_in  input  1  synchronous active-high reset.
REQ-005 Port: st_valid_in  input  1  128-bit state job offered.
REQ-006 Port: st_ready_out  output  1  state job accepted when high together with st_valid_in.
REQ-007 Port: st_in  input  128  state; byte i = st_in[8i+7:8i].
REQ-008 Port: st_valid_out  output  1  one-cycle pulse, st_out valid.
REQ-009 Port: st_out  output  128  SubBytes(st_in), same byte order.
REQ-010 Port: kw_valid_in  input  1  32-bit key-schedule word job offered.
REQ-011 Port: kw_ready_out  output  1  key job accepted when high together with kw_valid_in.
REQ-012 Port: kw_in  input  32  word; byte i = kw_in[8i+7:8i].
REQ-013 Port: kw_valid_out  output  1  one-cycle pulse, kw_out valid.
REQ-014 Port: kw_out  output  32  SubWord(kw_in).
REQ-015 Port: sbox_x_out  output  8  byte to the shared external S-box pipeline.
REQ-016 Port: sbox_x_valid_out  output  1  sbox_x_out carries a live byte.
REQ-017 Port: sbox_y_in  input  8  S-box result, SBOX_LAT cycles after issue; no valid qualifier.
REQ-018 Port: busy_out  output  1  high while any state other than IDLE is active.

Function
REQ-019 SHALL implement FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE; one job in flight at a time.
REQ-020 In IDLE, st_ready_out and kw_ready_out SHALL be high per the grant rule; in all other states both SHALL be low.
REQ-021 Grant rule: only one requester valid -> grant it; both valid -> grant the one not granted last (round-robin); the ungranted ready SHALL be low that cycle.
REQ-022 On handshake (cycle c0) SHALL register the job data and length N (16 state, 4 key) and enter ISSUE.
REQ-023 ISSUE SHALL drive byte k on sbox_x_out with sbox_x_valid_out=1 in cycle c0+1+k, k=0..N-1, one byte per cycle, no gaps; then enter WAIT.
REQ-024 Outside ISSUE, sbox_x_out SHALL be 0 and sbox_x_valid_out 0.
REQ-025 SHALL track returns with an SBOX_LAT-deep valid shift register; sbox_y_in is captured into result byte j only when the tracked bit for issue j arrives (cycle c0+1+j+SBOX_LAT).
REQ-026 After byte N-1 is captured, SHALL enter DONE; DONE asserts exactly one of st_valid_out/kw_valid_out for one cycle, at cycle c0+N+SBOX_LAT+1 (19 cycles for state, 7 for key at SBOX_LAT=2).
REQ-027 No output backpressure; st_out/kw_out SHALL hold their value until the next pulse of the same type.
REQ-028 Earliest next handshake SHALL be the cycle after DONE.
REQ-029 Input data changes after the handshake SHALL NOT affect the running job.

Reset
REQ-030 With rst_in high at an edge: FSM to IDLE, return tracker cleared, round-robin pointer = state-last (key wins first tie), all outputs 0 except ready ports, which SHALL be 0 during reset.
REQ-031 Reset mid-job SHALL abandon the job with no valid pulse; stale sbox_y_in values still in the external pipeline SHALL be ignored.
REQ-032 In the first cycle after rst_in falls, ready SHALL follow REQ-021.

Verification (bench models the S-box as an SBOX_LAT-stage AES S-box)
REQ-033 st_in = all 0x00 -> st_out = all 0x63, st_valid_out exactly 19 cycles after the handshake, single pulse.
REQ-034 kw_in = 0x00000053 -> kw_out = 0x636363ED, kw_valid_out 7 cycles after the handshake.
REQ-035 After reset, both valid simultaneously -> key granted first; next tie -> state granted; third tie -> key.
REQ-036 rst_in pulsed during issue of byte 8 of a state job -> no st_valid_out; next job (st_in all 0x53) -> all 0xED, correct latency.
REQ-037 st_valid_in held high with a fresh random state each job -> handshakes every 20 cycles, 16-cycle sbox_x_valid_out bursts, all results match the model.
REQ-038 Repeat REQ-033 with SBOX_LAT=1 and 8 -> pulse at 18 and 25 cycles respectively.
